bin_to_bcd_stream: RTL and testbench
====================================

# bin_to_bcd_stream

Parametrised sequential binary-to-BCD converter using double dabble, one bit per clock. It has a valid/ready handshake on both sides and an input capture register, so the source may change its data after acceptance. It flags results too wide for the configured digit count and has an optional signed mode. It sits between arithmetic or counter logic and the seven-segment display drivers.

## Interface
- `BIN_W`, 32: width of the binary input in bits (≥ 4).
- `BCD_DIGITS`, 10: number of BCD digits produced (≥ 1). 10 covers the full 32-bit unsigned range.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `in_valid` input 1: `in_data` holds a value to convert.
- `in_ready` output 1: the block accepts `in_data` this cycle.
- `in_data` input `BIN_W`: binary value. Unsigned, or two's complement with `BIN2BCD_SIGNED_EN`.
- `out_valid` output 1: the result outputs are valid and held.
- `out_ready` input 1: the consumer takes the result this cycle.
- `bcd` output `4*BCD_DIGITS`: packed BCD result; digit 0 is `bcd[3:0]`.
- `sign` output 1: result is negative. Tied 0 without `BIN2BCD_SIGNED_EN`.
- `overflow` output 1: the value needed more than `BCD_DIGITS` digits; `bcd` holds the low digits.
- `idle` output 1: the FSM is in `S_IDLE`.

## Operation
- The FSM has three states: `S_IDLE`, `S_CONV`, `S_DONE`. One-hot encoding.
- **Accept.** A value is accepted when `in_valid && in_ready` is high at a clock edge. On acceptance:
  - `in_data` (or its magnitude in signed mode) is latched into the operand register;
  - the BCD shift register and the sticky overflow bit are cleared;
  - the bit counter is loaded with `BIN_W`;
  - the FSM moves to `S_CONV`.
- **`S_CONV` step.** Every cycle in this state:
  - each 4-bit digit ≥ 5 gets +3 (mod 16);
  - then the {digits, operand} register shifts left by 1, with the operand MSB entering digit 0 bit 0;
  - a 1 shifted out of the top digit's bit 3 sets the sticky overflow bit;
  - the counter decrements.
- **End of `S_CONV`.** When the counter reaches 1, the final step is done and the following all update on the same edge:
  - the FSM moves to `S_DONE`;
  - `bcd`, `sign` and `overflow` are registered from the shift register and the flags.
- **`S_DONE`.** `out_valid` = 1. `bcd`, `sign` and `overflow` stay stable until `out_valid && out_ready`. On that handshake:
  - with `in_valid` high, the new value is accepted on the same edge and the FSM goes to `S_CONV`;
  - otherwise the FSM goes to `S_IDLE`.
- `in_ready = S_IDLE || (S_DONE && out_ready)`. This is a combinational path from `out_ready`.
- `in_valid` is ignored in `S_CONV`; a held `in_valid` is simply accepted later.
- Outputs stay at their last values in `S_IDLE` and `S_CONV`; `out_valid` qualifies them.
- Any undefined state encoding returns to `S_IDLE`.

## Timing
- Reset values:
  - FSM in `S_IDLE`, so `idle` = 1 and `in_ready` = 1;
  - `out_valid` = 0, `bcd` = 0, `sign` = 0, `overflow` = 0;
  - internal registers = 0.
- Reset asserted mid-conversion aborts immediately; no partial result is ever presented.
- Latency: accept at edge k gives `out_valid` = 1 after edge k + `BIN_W` (e.g. 32 cycles for `BIN_W` = 32).
- Throughput: with `out_ready` held 1 and `in_valid` held 1, one result per `BIN_W` + 1 cycles.
- The counter is `$clog2(BIN_W+1)` bits wide. No arithmetic wider than 4 bits outside the counter.

## Configuration
- `BIN2BCD_SIGNED_EN` defined (signed mode):
  - `in_data` is two's complement;
  - on acceptance the magnitude (`-in_data` if the MSB is set) is latched and `sign` is latched from the MSB;
  - −2^(`BIN_W`−1) converts to its magnitude 2^(`BIN_W`−1) with `sign` = 1;
  - zero always gives `sign` = 0.
- Not defined (unsigned mode): `in_data` is unsigned, `sign` is constant 0, and no negation logic is generated.

## Structure
- Package `bin_to_bcd_pkg` holds:
  - the state typedef (`S_IDLE`, `S_CONV`, `S_DONE`);
  - function `bcd_digits_for(width)`, returning ceil(width·log10 2), for callers sizing `BCD_DIGITS`.
- Sub-module `bcd_add3_digit` is the combinational 4-bit "≥ 5 → +3" cell, instantiated `BCD_DIGITS` times in a generate loop.

## Test plan
- Reset, then `in_data` = 0 (`BIN_W` = 32, `BCD_DIGITS` = 10) → after 32 cycles `bcd` = 0x0000000000, `overflow` = 0, `sign` = 0.
- `in_data` = 4294967295 → `bcd` = 0x4294967295, `overflow` = 0, latency exactly 32 cycles from acceptance. Change `in_data` after acceptance → result unaffected.
- `BCD_DIGITS` = 8, `in_data` = 100000000 → `bcd` = 0x00000000, `overflow` = 1. Then 99999999 → `bcd` = 0x99999999, `overflow` = 0.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid` → `bcd` stable and `in_ready` = 0. Then raise `out_ready` with `in_valid` = 1 and `in_data` = 12345 → same-edge acceptance, next result 0x0000012345.
- Deassert `rst_n` 10 cycles into a conversion → all outputs at reset values, `idle` = 1. After reset release a fresh conversion of 7 → 0x0000000007.
- Signed (`BIN2BCD_SIGNED_EN`, `BIN_W` = 16, `BCD_DIGITS` = 5):
  - −1234 → `bcd` = 0x01234, `sign` = 1;
  - −32768 → `bcd` = 0x32768, `sign` = 1;
  - 0 → `sign` = 0.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and helpers for the streaming binary-to-BCD converter.
// Holds the one-hot FSM state type and a digit-count sizing helper.
package bin_to_bcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_CONV = 3'b010,
    S_DONE = 3'b100
  } state_e;

  // ceil(width * log10(2)) in integer arithmetic (log10 2 ~ 0.30103)
  function automatic int bcd_digits_for(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin_to_bcd_stream_if.sv
// Valid/ready bundle between a binary source, the converter
// and the BCD consumer.
interface bin_to_bcd_stream_if #(
  parameter int BIN_W      = 32,
  parameter int BCD_DIGITS = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [BIN_W-1:0]        in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic                    sign;
  logic                    overflow;
  logic                    idle;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bcd, sign, overflow, idle
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bcd, sign, overflow, idle
  );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 (mod 16).
module bcd_add3_digit (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

// File: rtl/bin_to_bcd_stream.sv
// Streaming double-dabble converter, one bit per clock, valid/ready both sides.
// Define BIN2BCD_SIGNED_EN for two's complement input with a sign output.
module bin_to_bcd_stream
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W      = 32,
  parameter int BCD_DIGITS = 10
) (
  input logic                clk,
  input logic                rst_n,
  bin_to_bcd_stream_if.slave bus
);
  localparam int DW    = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(BIN_W);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [BIN_W-1:0] r_op;
  logic [DW-1:0]    r_dig;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic [DW-1:0]    r_bcd;
  logic             r_sign;
  logic             r_ovf_o;

  logic             w_acc;
  logic             w_last;
  logic             w_carry;
  logic [DW-1:0]    w_adj;
  logic [DW-1:0]    w_dig_sh;
  logic [BIN_W-1:0] w_mag;
  logic             w_neg;

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dig
    bcd_add3_digit u_add3 (
      .i_d (r_dig[4*gi +: 4]),
      .o_d (w_adj[4*gi +: 4])
    );
  end

  assign w_carry  = w_adj[DW-1];
  assign w_dig_sh = {w_adj[DW-2:0], r_op[BIN_W-1]};

`ifdef BIN2BCD_SIGNED_EN
  // -MIN wraps to MIN, which is exactly its unsigned magnitude
  assign w_neg = bus.in_data[BIN_W-1];
  assign w_mag = w_neg ? -bus.in_data : bus.in_data;
`else
  assign w_neg = 1'b0;
  assign w_mag = bus.in_data;
`endif

  assign bus.in_ready  = (r_state == S_IDLE) ||
                         ((r_state == S_DONE) && bus.out_ready);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.idle      = (r_state == S_IDLE);
  assign bus.bcd       = r_bcd;
  assign bus.sign      = r_sign;
  assign bus.overflow  = r_ovf_o;

  assign w_acc  = bus.in_valid && bus.in_ready;
  assign w_last = (r_state == S_CONV) && (r_cnt == CNT_ONE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (bus.in_valid) w_state_nxt = S_CONV;
      S_CONV: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready)
                w_state_nxt = bus.in_valid ? S_CONV : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_dig   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_bcd   <= '0;
      r_sign  <= 1'b0;
      r_ovf_o <= 1'b0;
    end else if (w_acc) begin
      r_op  <= w_mag;
      r_dig <= '0;
      r_ovf <= 1'b0;
      r_cnt <= CNT_LD;
      r_neg <= w_neg;
    end else if (r_state == S_CONV) begin
      r_op  <= {r_op[BIN_W-2:0], 1'b0};
      r_dig <= w_dig_sh;
      r_ovf <= r_ovf | w_carry;
      r_cnt <= r_cnt - CNT_ONE;
      if (w_last) begin
        r_bcd   <= w_dig_sh;
        r_sign  <= r_neg;
        r_ovf_o <= r_ovf | w_carry;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// Scoreboard bench for bin_to_bcd_stream: a wide instance (signed 16/5 when
// BIN2BCD_SIGNED_EN is defined, else 32/10) and a 32/8 instance for overflow.
module tb_bin_to_bcd_stream;

`ifdef BIN2BCD_SIGNED_EN
  localparam int AW = 16;
  localparam int AD = 5;
  localparam logic [AW-1:0] V1 = AW'(-1234);
  localparam logic [39:0]   E1 = 40'h01234;
  localparam logic          S1 = 1'b1;
  localparam logic [AW-1:0] V2 = AW'(-32768);
  localparam logic [39:0]   E2 = 40'h32768;
  localparam logic          S2 = 1'b1;
`else
  localparam int AW = 32;
  localparam int AD = 10;
  localparam logic [AW-1:0] V1 = 32'hFFFF_FFFF;
  localparam logic [39:0]   E1 = 40'h4294967295;
  localparam logic          S1 = 1'b0;
  localparam logic [AW-1:0] V2 = AW'(31);
  localparam logic [39:0]   E2 = 40'h31;
  localparam logic          S2 = 1'b0;
`endif
  localparam int BW = 32;
  localparam int BD = 8;

  typedef struct packed {
    logic        ovf;
    logic        sgn;
    logic [39:0] bcd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];

  bin_to_bcd_stream_if #(.BIN_W(AW), .BCD_DIGITS(AD)) ia ();
  bin_to_bcd_stream_if #(.BIN_W(BW), .BCD_DIGITS(BD)) ib ();

  bin_to_bcd_stream #(.BIN_W(AW), .BCD_DIGITS(AD)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  bin_to_bcd_stream #(.BIN_W(BW), .BCD_DIGITS(BD)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic o, input logic s,
                              input logic [39:0] b);
    exp_t e;
    e.ovf = o;
    e.sgn = s;
    e.bcd = b;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_result", 64'(ia.bcd), 64'h0);
        chk("a_unexpected_count", 64'(1), 64'(0));
      end else begin
        e = qa.pop_front();
        chk("a_bcd", 64'(ia.bcd), 64'(e.bcd));
        chk("a_sign", 64'(ia.sign), 64'(e.sgn));
        chk("a_ovf", 64'(ia.overflow), 64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_count", 64'(1), 64'(0));
      end else begin
        e = qb.pop_front();
        chk("b_bcd", 64'(ib.bcd), 64'(e.bcd));
        chk("b_sign", 64'(ib.sign), 64'(e.sgn));
        chk("b_ovf", 64'(ib.overflow), 64'(e.ovf));
      end
    end
  end

  task automatic send_a(input logic [AW-1:0] v, input exp_t e,
                        input bit push, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    ia.in_valid = 1'b1;
    ia.in_data  = v;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = ia.in_ready;
      @(posedge clk);
      if (!acc) waited++;
    end
    if (!acc) chk("a_accept_timeout", 64'(waited), 64'(0));
    else if (push) qa.push_back(e);
    #1;
    ia.in_valid = 1'b0;
    ia.in_data  = ~v;
  endtask

  task automatic send_b(input logic [BW-1:0] v, input exp_t e);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    ib.in_valid = 1'b1;
    ib.in_data  = v;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = ib.in_ready;
      @(posedge clk);
      if (!acc) waited++;
    end
    if (!acc) chk("b_accept_timeout", 64'(waited), 64'(0));
    else qb.push_back(e);
    #1;
    ib.in_valid = 1'b0;
    ib.in_data  = ~v;
  endtask

  task automatic wait_valid_a(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ia.out_valid && n < 200);
    if (!ia.out_valid) chk("a_valid_timeout", 64'(n), 64'(AW));
  endtask

  task automatic drain_a();
    for (int i = 0; i < 200 && qa.size() != 0; i++) @(posedge clk);
    chk("a_drain", 64'(qa.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    for (int i = 0; i < 200 && qb.size() != 0; i++) @(posedge clk);
    chk("b_drain", 64'(qb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_idle"}, 64'(ia.idle), 64'(1));
    chk({tag, "_in_ready"}, 64'(ia.in_ready), 64'(1));
    chk({tag, "_out_valid"}, 64'(ia.out_valid), 64'(0));
    chk({tag, "_bcd"}, 64'(ia.bcd), 64'(0));
    chk({tag, "_sign"}, 64'(ia.sign), 64'(0));
    chk({tag, "_ovf"}, 64'(ia.overflow), 64'(0));
  endtask

  initial begin
    int n;
    logic [39:0] held;
    ia.in_valid = 1'b0; ia.in_data = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_a("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_a('0, mk(1'b0, 1'b0, 40'h0), 1'b1, n);
    drain_a();

    send_a(V1, mk(1'b0, S1, E1), 1'b1, n);
    wait_valid_a(n);
    chk("a_latency", 64'(n), 64'(AW));
    drain_a();

    ia.out_ready = 1'b0;
    send_a(V2, mk(1'b0, S2, E2), 1'b1, n);
    wait_valid_a(n);
    held = 40'(ia.bcd);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_bcd_stable", 64'(ia.bcd), 64'(E2));
      chk("bp_held", 64'(ia.bcd), 64'(held));
      chk("bp_in_ready", 64'(ia.in_ready), 64'(0));
      chk("bp_out_valid", 64'(ia.out_valid), 64'(1));
    end
    ia.out_ready = 1'b1;
    send_a(AW'(12345), mk(1'b0, 1'b0, 40'h12345), 1'b1, n);
    chk("same_edge_wait", 64'(n), 64'(0));
    chk("same_edge_conv_valid", 64'(ia.out_valid), 64'(0));
    chk("same_edge_conv_idle", 64'(ia.idle), 64'(0));
    drain_a();

    send_a(AW'(999), mk(1'b0, 1'b0, 40'h999), 1'b0, n);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_a("mid_rst");
    @(posedge clk);
    #1;
    chk("mid_rst_valid_hold", 64'(ia.out_valid), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_a(AW'(7), mk(1'b0, 1'b0, 40'h7), 1'b1, n);
    drain_a();

    send_b(32'd100000000, mk(1'b1, 1'b0, 40'h0));
    drain_b();
    send_b(32'd99999999, mk(1'b0, 1'b0, 40'h99999999));
    drain_b();
`ifdef BIN2BCD_SIGNED_EN
    send_b(32'hFFFF_FFFB, mk(1'b0, 1'b1, 40'h5));
    drain_b();
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
